ad_cal_multi: RTL
=================

# ad_cal_multi

Multi-channel, parametrised delay-tap calibration engine for the ADS42 capture path. After ADC initialisation it drives each channel in ramp test-pattern mode through the full data-delay tap range and checks the captured ramp at every tap. It then picks the centre of the longest error-free tap window per channel and programs every channel back to normal mode with that tap. It sits between the ADC SPI/configuration controller (request/acknowledge handshake) and the de-serialised ADC data bus.

## Interface
- CH_NUM, 2: number of ADC channels calibrated (1..8)
- DW, 16: sample width per channel
- TAP_W, 3: tap code width; TAPS = 2^TAP_W taps, codes 0..TAPS-1
- SETTLE_CYC, 256: wait cycles after each configuration acknowledge
- CMP_LEN, 1024: valid samples checked per tap
- TO_CYC, 65535: handshake timeout in cycles
- CH_W (derived): max(1, clog2(CH_NUM))

- sys_clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_ad_inital_over  in  1  ADC init complete (level)
- i_start  in  1  single-cycle start/recalibrate pulse
- o_ad_mode  out  4  4'b0100 ramp test mode, 4'b0000 normal
- o_ad_ch  out  CH_W  channel being configured
- o_ad_dly  out  TAP_W  tap code being configured
- o_ad_cfg_req  out  1  configuration request
- i_ad_cfg_ack  in  1  configuration done/acknowledge
- i_ad_data  in  CH_NUM*DW  channel c at [c*DW +: DW], sys_clk-synchronous
- i_ad_valid  in  1  sample strobe for i_ad_data
- o_busy  out  1  calibration running
- o_done  out  1  one-cycle completion pulse
- o_fail  out  1  sticky: channel with no passing tap, or timeout
- o_pass_map  out  CH_NUM*TAPS  per-channel pass bit per tap
- o_tap_res  out  CH_NUM*TAP_W  selected tap per channel

## Operation
- States: IDLE, REQ, ACK_WAIT, REL_WAIT, SETTLE, COMP, EVAL, SET, DONE.
- IDLE: i_start with i_ad_inital_over high clears o_fail and o_pass_map, sets ch=0, tap=0, mode=0100, and enters REQ. i_start with i_ad_inital_over low, or while o_busy, is ignored.
- Handshake (4-phase): REQ asserts o_ad_cfg_req and goes to ACK_WAIT. On ack=1, req drops and the block goes to REL_WAIT. On ack=0 it continues to SETTLE (sweep) or to the next SET / DONE (final programming).
- SETTLE counts SETTLE_CYC cycles, then enters COMP.
- COMP: the first valid sample only loads the previous-sample register. Each later valid sample is checked with sample == (prev + 1) mod 2^DW, channel o_ad_ch only. Any mismatch marks the tap as failing. After CMP_LEN checked samples, pass_map[ch][tap] is written. If tap < TAPS-1: tap++, then REQ. Otherwise EVAL.
- EVAL scans taps 0..TAPS-1, one per cycle, for the longest contiguous run of 1s, with no wrap-around. On a tie the lower start wins. tap_res = start + (len-1)>>1 (floor). If len=0: tap_res=0 and o_fail=1. Then, if ch < CH_NUM-1: ch++, tap=0, REQ. Otherwise SET with ch=0.
- SET: mode=0000, o_ad_dly=tap_res[ch], handshake. Repeated for every channel, then DONE.
- Timeout: a counter restarts on entry to ACK_WAIT and to REL_WAIT. Reaching TO_CYC sets o_fail, drops req, forces mode=0000, and goes to DONE.
- DONE: o_done=1 for one cycle, o_busy=0, then IDLE. Results are held until the next start.

## Timing
- Reset values: o_ad_mode=0, o_ad_ch=0, o_ad_dly=0, o_ad_cfg_req=0, o_busy=0, o_done=0, o_fail=0, o_pass_map=0, o_tap_res=0. State returns to IDLE.
- Reset mid-operation: all of the above apply the cycle after rst is sampled. Partial results are discarded.
- o_busy rises the cycle after the accepted i_start and falls in the same cycle o_done rises.
- o_ad_mode, o_ad_ch and o_ad_dly change one or more cycles before o_ad_cfg_req rises. They stay stable until REL_WAIT exits.
- o_ad_cfg_req rises 1 cycle after REQ is entered and falls 1 cycle after ack=1 is sampled.
- Comparison is 1 cycle registered. i_ad_valid gaps extend COMP; they never count as samples.
- Ack high already on entry to ACK_WAIT is accepted immediately.
- Simultaneous timeout and ack in the same cycle: the ack wins.

## Test plan
- CH_NUM=2, TAP_W=3, ideal ramp, ack 5 cycles after req: pass_map=0xFF/0xFF, tap_res=3/3, o_fail=0. The final SET writes mode 0 with dly 3 to both channels, and o_done pulses once.
- Ramp corrupted on ch0 taps 0, 1 and 7, and on ch1 taps 4..7: pass_map ch0=0x7C, ch1=0x0F; tap_res ch0=4, ch1=1.
- ch0 passes taps 0..2 and 5..7 only (two equal windows): tie takes the lower window, tap_res ch0=1.
- ch1 corrupted at every tap: o_fail=1, tap_res ch1=0, ch0=3; both SETs still issued, o_done pulses.
- Ack never asserted at the first REQ: after TO_CYC cycles req=0, mode=0000, o_fail=1, o_done pulse, o_busy=0.
- rst pulsed during COMP of ch0 tap 2: next cycle all outputs are at reset values. A subsequent i_start restarts from ch0 tap 0. An i_start issued while busy causes no restart.

Source files
------------

// File: rtl/ad_cal_multi.sv
// ad_cal_multi: sweeps each ADC channel's data-delay taps against a ramp pattern,
// picks the centre of the longest passing window, then programs every channel with it.
module ad_cal_multi #(
  parameter int CH_NUM = 2,
  parameter int DW = 16,
  parameter int TAP_W = 3,
  parameter int SETTLE_CYC = 256,
  parameter int CMP_LEN = 1024,
  parameter int TO_CYC = 65535,
  localparam int CH_W = CH_NUM > 1 ? $clog2(CH_NUM) : 1,
  localparam int TAPS = 1 << TAP_W
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    i_ad_inital_over,
  input  logic                    i_start,
  output logic [3:0]              o_ad_mode,
  output logic [CH_W-1:0]         o_ad_ch,
  output logic [TAP_W-1:0]        o_ad_dly,
  output logic                    o_ad_cfg_req,
  input  logic                    i_ad_cfg_ack,
  input  logic [CH_NUM*DW-1:0]    i_ad_data,
  input  logic                    i_ad_valid,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_fail,
  output logic [CH_NUM*TAPS-1:0]  o_pass_map,
  output logic [CH_NUM*TAP_W-1:0] o_tap_res
);
  typedef enum logic [3:0] {IDLE, REQ, ACK_WAIT, REL_WAIT, SETTLE, COMP, EVAL, SET, DONE} state_t;
  state_t state;
  logic [31:0] cnt;
  logic [DW-1:0] prev, sample;
  logic have_prev, chk_v, chk_ok, err, bit_v, sweep;
  logic [TAP_W-1:0] idx, cur_start, best_start, run_start, nb_start;
  logic [TAP_W:0] cur_len, best_len, run_len, nb_len;
  // running longest-window search including the bit scanned this cycle
  always_comb begin
    sample = i_ad_data[o_ad_ch*DW +: DW];
    bit_v = o_pass_map[o_ad_ch*TAPS + idx];
    run_len = bit_v ? cur_len + 1'b1 : '0;
    run_start = cur_len == '0 ? idx : cur_start;
    nb_len = run_len > best_len ? run_len : best_len;
    nb_start = run_len > best_len ? run_start : best_start;
    sweep = o_ad_mode == 4'b0100;
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      prev <= '0;
      have_prev <= 1'b0;
      chk_v <= 1'b0;
      chk_ok <= 1'b0;
      err <= 1'b0;
      idx <= '0;
      cur_start <= '0;
      best_start <= '0;
      cur_len <= '0;
      best_len <= '0;
      o_ad_mode <= '0;
      o_ad_ch <= '0;
      o_ad_dly <= '0;
      o_ad_cfg_req <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_fail <= 1'b0;
      o_pass_map <= '0;
      o_tap_res <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start && i_ad_inital_over) begin
            o_fail <= 1'b0;
            o_pass_map <= '0;
            o_ad_ch <= '0;
            o_ad_dly <= '0;
            o_ad_mode <= 4'b0100;
            o_busy <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          o_ad_cfg_req <= 1'b1;
          cnt <= '0;
          state <= ACK_WAIT;
        end
        ACK_WAIT, REL_WAIT: begin
          cnt <= cnt + 1'b1;
          if (state == ACK_WAIT && i_ad_cfg_ack) begin
            o_ad_cfg_req <= 1'b0;
            cnt <= '0;
            state <= REL_WAIT;
          end else if (state == REL_WAIT && !i_ad_cfg_ack) begin
            cnt <= '0;
            if (sweep) state <= SETTLE;
            else if (o_ad_ch == CH_W'(CH_NUM-1)) state <= DONE;
            else begin
              o_ad_ch <= o_ad_ch + 1'b1;
              state <= SET;
            end
          end else if (cnt == 32'(TO_CYC-1)) begin
            o_fail <= 1'b1;
            o_ad_cfg_req <= 1'b0;
            o_ad_mode <= '0;
            state <= DONE;
          end
        end
        SETTLE: begin
          cnt <= cnt + 1'b1;
          have_prev <= 1'b0;
          chk_v <= 1'b0;
          err <= 1'b0;
          if (cnt == 32'(SETTLE_CYC-1)) begin
            cnt <= '0;
            state <= COMP;
          end
        end
        COMP: begin
          if (i_ad_valid) begin
            prev <= sample;
            have_prev <= 1'b1;
            chk_v <= have_prev;
            chk_ok <= sample == prev + DW'(1);
          end else chk_v <= 1'b0;
          if (chk_v) begin
            if (cnt == 32'(CMP_LEN-1)) begin
              o_pass_map[o_ad_ch*TAPS + o_ad_dly] <= ~err & chk_ok;
              if (o_ad_dly == TAP_W'(TAPS-1)) begin
                idx <= '0;
                cur_len <= '0;
                cur_start <= '0;
                best_len <= '0;
                best_start <= '0;
                state <= EVAL;
              end else begin
                o_ad_dly <= o_ad_dly + 1'b1;
                state <= REQ;
              end
            end else begin
              cnt <= cnt + 1'b1;
              err <= err | ~chk_ok;
            end
          end
        end
        EVAL: begin
          cur_len <= run_len;
          cur_start <= run_start;
          best_len <= nb_len;
          best_start <= nb_start;
          idx <= idx + 1'b1;
          if (idx == TAP_W'(TAPS-1)) begin
            o_tap_res[o_ad_ch*TAP_W +: TAP_W] <= nb_len == '0 ? '0 : nb_start + TAP_W'((nb_len - 1'b1) >> 1);
            if (nb_len == '0) o_fail <= 1'b1;
            if (o_ad_ch == CH_W'(CH_NUM-1)) begin
              o_ad_ch <= '0;
              state <= SET;
            end else begin
              o_ad_ch <= o_ad_ch + 1'b1;
              o_ad_dly <= '0;
              state <= REQ;
            end
          end
        end
        SET: begin
          o_ad_mode <= '0;
          o_ad_dly <= o_tap_res[o_ad_ch*TAP_W +: TAP_W];
          state <= REQ;
        end
        DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
